// File: rtl/ahb3lite_burst_master_if.sv
// Command-side and AHB3-Lite bus signals of ahb3lite_burst_master.
// The master modport is the initiator's view; the slave modport is the fabric/bench view.
interface ahb3lite_burst_master_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic [2:0]        cmd_burst;
    logic [4:0]        cmd_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ack;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_len, wdata,
        input  HREADY, HRESP, HRDATA,
        output cmd_ready, wdata_ack, rdata, rdata_valid, done, err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_len, wdata,
        output HREADY, HRESP, HRDATA,
        input  cmd_ready, wdata_ack, rdata, rdata_valid, done, err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );
endinterface

// File: rtl/ahb3lite_burst_master.sv
// AHB3-Lite burst initiator: one command becomes a pipelined NONSEQ/SEQ burst (INCR/WRAP).
// Define AHB_MASTER_ALIGN_CHECK_EN to reject commands whose address is not size-aligned.
module ahb3lite_burst_master #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 32,
    parameter logic [3:0]  HPROT_DEFAULT = 4'b0011
) (
    input logic                   HCLK,
    input logic                   HRESET,
    ahb3lite_burst_master_if.master bus
);
    localparam int unsigned MaxSize  = $clog2(DATA_W / 8);
    localparam logic [1:0]  HtIdle   = 2'b00;
    localparam logic [1:0]  HtNonseq = 2'b10;
    localparam logic [1:0]  HtSeq    = 2'b11;

    typedef enum logic [2:0] {StIdle, StAddr, StBurst, StLast, StErr1, StErr2} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d, wmask_q, wmask_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d, hburst_q, hburst_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d, rdata_q, rdata_d;
    logic [4:0]        beats_left_q, beats_left_d;
    logic              rdata_valid_q, rdata_valid_d, done_q, done_d, err_q, err_d;

    logic [4:0]        beats;
    logic [31:0]       total_bytes, end_off;
    logic              is_wrap, reject, align_bad, addr_done;
    logic [ADDR_W-1:0] mask_cmd, next_addr;

    always_comb begin
        unique case (bus.cmd_burst)
            3'b000:         beats = 5'd1;
            3'b001:         beats = (bus.cmd_len == 5'd0) ? 5'd1 : bus.cmd_len;
            3'b010, 3'b011: beats = 5'd4;
            3'b100, 3'b101: beats = 5'd8;
            default:        beats = 5'd16;
        endcase
    end

    assign total_bytes = 32'(beats) << bus.cmd_size;
    assign end_off     = 32'(bus.cmd_addr[9:0]) + total_bytes;
    assign is_wrap     = !bus.cmd_burst[0] && (bus.cmd_burst != 3'b000);
    assign mask_cmd    = is_wrap ? ADDR_W'(total_bytes - 32'd1) : '1;
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    assign align_bad = |(bus.cmd_addr & ((ADDR_W'(1) << bus.cmd_size) - ADDR_W'(1)));
`else
    assign align_bad = 1'b0;
`endif
    assign reject = (32'(bus.cmd_size) > MaxSize) || (bus.cmd_burst[0] && (end_off > 32'd1024)) ||
                    align_bad;

    // Non-wrap bursts carry an all-ones mask, so the same expression does plain increment.
    assign next_addr = (haddr_q & ~wmask_q) |
                       ((haddr_q + (ADDR_W'(1) << hsize_q)) & wmask_q);
    assign addr_done = bus.HREADY && (htrans_q != HtIdle);

    always_comb begin
        state_d       = state_q;
        haddr_d       = haddr_q;
        htrans_d      = htrans_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hburst_d      = hburst_q;
        hwdata_d      = hwdata_q;
        wmask_d       = wmask_q;
        beats_left_d  = beats_left_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        if (addr_done && hwrite_q) hwdata_d = bus.wdata;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    if (reject) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        haddr_d      = bus.cmd_addr;
                        htrans_d     = HtNonseq;
                        hwrite_d     = bus.cmd_write;
                        hsize_d      = bus.cmd_size;
                        hburst_d     = bus.cmd_burst;
                        wmask_d      = mask_cmd;
                        beats_left_d = beats - 5'd1;
                        state_d      = StAddr;
                    end
                end
            end
            StAddr, StBurst: begin
                if (state_q == StBurst && bus.HRESP && !bus.HREADY) begin
                    htrans_d = HtIdle;
                    state_d  = StErr1;
                end else if (bus.HREADY) begin
                    if (state_q == StBurst && !hwrite_q) begin
                        rdata_d       = bus.HRDATA;
                        rdata_valid_d = 1'b1;
                    end
                    if (beats_left_q == 5'd0) begin
                        htrans_d = HtIdle;
                        state_d  = StLast;
                    end else begin
                        haddr_d      = next_addr;
                        htrans_d     = HtSeq;
                        beats_left_d = beats_left_q - 5'd1;
                        state_d      = StBurst;
                    end
                end
            end
            StLast: begin
                if (bus.HRESP && !bus.HREADY) begin
                    state_d = StErr1;
                end else if (bus.HREADY) begin
                    if (!hwrite_q) begin
                        rdata_d       = bus.HRDATA;
                        rdata_valid_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StErr1: begin
                if (bus.HREADY) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StErr2;
                end
            end
            StErr2:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= StIdle;
            haddr_q       <= '0;
            htrans_q      <= HtIdle;
            hwrite_q      <= 1'b0;
            hsize_q       <= '0;
            hburst_q      <= '0;
            hwdata_q      <= '0;
            wmask_q       <= '0;
            beats_left_q  <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            haddr_q       <= haddr_d;
            htrans_q      <= htrans_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hburst_q      <= hburst_d;
            hwdata_q      <= hwdata_d;
            wmask_q       <= wmask_d;
            beats_left_q  <= beats_left_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.wdata_ack   = addr_done && hwrite_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.HADDR       = haddr_q;
    assign bus.HTRANS      = htrans_q;
    assign bus.HWRITE      = hwrite_q;
    assign bus.HSIZE       = hsize_q;
    assign bus.HBURST      = hburst_q;
    assign bus.HPROT       = HPROT_DEFAULT;
    assign bus.HWDATA      = hwdata_q;
endmodule
